alu_ctrl: RTL and testbench

Instruction sequencer that drives the `alu` datapath and the `alu_regs` register file. It accepts 16-bit instruction words over a valid/ready handshake and reads two source registers through the register file's read selects. It runs the operation through `alu`, then writes the result back through the register file's write port. It also records carry/zero flags and a retired-instruction count for the rest of the design.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_ctrl_if.sv | 9 +
 rtl/alu_ctrl_decode.sv | 27 ++
 rtl/alu_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and instruction field layout for the alu_ctrl sequencer.
package alu_pkg;

   typedef enum logic [2:0] {
      OpAdd  = 3'b000,
      OpSub  = 3'b001,
      OpAnd  = 3'b010,
      OpOr   = 3'b011,
      OpNor  = 3'b100,
      OpXor  = 3'b101,
      OpXnor = 3'b110,
      OpNand = 3'b111
   } alu_op_t;

   localparam int unsigned InstrW  = 16;
   localparam int unsigned OpMsb   = 15;
   localparam int unsigned OpLsb   = 13;
   localparam int unsigned BankBit = 12;
   localparam int unsigned DstMsb  = 11;
   localparam int unsigned DstLsb  = 9;
   localparam int unsigned SrcAMsb = 8;
   localparam int unsigned SrcALsb = 6;
   localparam int unsigned SrcBMsb = 5;
   localparam int unsigned SrcBLsb = 3;

   localparam logic [3:0] BankSelA = 4'b0000;
   localparam logic [3:0] BankSelB = 4'b0001;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StExec,
      StWrite
   } state_t;

endpackage

// File: rtl/alu_ctrl_if.sv
// Instruction valid/ready channel into the sequencer.
interface alu_ctrl_if;
   logic        in_valid;
   logic [15:0] in_instr;
   logic        in_ready;

   modport master (output in_valid, output in_instr, input in_ready);
   modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/alu_ctrl_decode.sv
// Splits the latched instruction into fields and forms the register-file write select.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [15:3] instr,
   output alu_op_t     op,
   output logic [2:0]  src_a,
   output logic [2:0]  src_b,
   output logic [6:0]  wrt_slct,
   output logic        wr_suppress
);

   logic       bank;
   logic [2:0] dst;

   always_comb begin
      op       = alu_op_t'(instr[OpMsb:OpLsb]);
      bank     = instr[BankBit];
      dst      = instr[DstMsb:DstLsb];
      src_a    = instr[SrcAMsb:SrcALsb];
      src_b    = instr[SrcBMsb:SrcBLsb];
      wrt_slct = bank ? {BankSelB, dst} : {BankSelA, dst};
      // A0 is the hard-wired zero register; writes to it are dropped.
      wr_suppress = !bank && (dst == 3'd0);
   end

endmodule

// File: rtl/alu_ctrl.sv
// Instruction sequencer: reads two registers, runs them through alu, writes the result back.
// One instruction per four cycles (IDLE, READ, EXEC, WRITE); keeps flags and a retired count.
module alu_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_ctrl_if.slave        in_if,
   output logic [2:0]       rd_slct_a,
   output logic [2:0]       rd_slct_b,
   input  logic [7:0]       data_out_a,
   input  logic [7:0]       data_out_b,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [2:0]       alu_op,
   input  logic [7:0]       alu_c,
   input  logic             alu_carry,
   input  logic             alu_zero,
   output logic             wrtnbl,
   output logic [6:0]       wrt_slct,
   output logic [7:0]       data_in,
   output logic             flag_carry,
   output logic             flag_zero,
   output logic             done,
   output logic [CNT_W-1:0] retired
);

   state_t           state_q, state_d;
   logic [15:3]      ir_q;
   logic [7:0]       opnd_a_q, opnd_b_q, result_q;
   alu_op_t          alu_op_q;
   logic [6:0]       wrt_slct_q;
   logic             carry_q, zero_q;
   logic             flag_carry_q, flag_zero_q, done_q;
   logic [CNT_W-1:0] retired_q;

   alu_op_t          dec_op;
   logic [6:0]       dec_wrt_slct;
   logic             dec_wr_suppress;

   alu_ctrl_decode u_decode (
      .instr       (ir_q),
      .op          (dec_op),
      .src_a       (rd_slct_a),
      .src_b       (rd_slct_b),
      .wrt_slct    (dec_wrt_slct),
      .wr_suppress (dec_wr_suppress)
   );

   always_comb begin
      state_d        = state_q;
      in_if.in_ready = 1'b0;
      wrtnbl         = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_if.in_ready = 1'b1;
            if (in_if.in_valid) state_d = StRead;
         end
         StRead:  state_d = StExec;
         StExec:  state_d = StWrite;
         StWrite: begin
            wrtnbl  = !dec_wr_suppress;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Each register loads only in its own state, so outputs hold between instructions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         ir_q         <= '0;
         opnd_a_q     <= '0;
         opnd_b_q     <= '0;
         alu_op_q     <= OpAdd;
         result_q     <= '0;
         carry_q      <= 1'b0;
         zero_q       <= 1'b0;
         wrt_slct_q   <= '0;
         flag_carry_q <= 1'b0;
         flag_zero_q  <= 1'b0;
         done_q       <= 1'b0;
         retired_q    <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (in_if.in_valid) ir_q <= in_if.in_instr[15:3];
            end
            StRead: begin
               opnd_a_q <= data_out_a;
               opnd_b_q <= data_out_b;
               alu_op_q <= dec_op;
            end
            StExec: begin
               result_q   <= alu_c;
               carry_q    <= alu_carry;
               zero_q     <= alu_zero;
               wrt_slct_q <= dec_wrt_slct;
            end
            StWrite: begin
               flag_carry_q <= carry_q;
               flag_zero_q  <= zero_q;
               retired_q    <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
               done_q       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign alu_a      = opnd_a_q;
   assign alu_b      = opnd_b_q;
   assign alu_op     = alu_op_q;
   assign wrt_slct   = wrt_slct_q;
   assign data_in    = result_q;
   assign flag_carry = flag_carry_q;
   assign flag_zero  = flag_zero_q;
   assign done       = done_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: register-file and ALU models around the DUT, scoreboard on done.
module tb_alu_ctrl;
   import alu_pkg::*;

   typedef struct packed {
      logic        wr;
      logic [6:0]  slct;
      logic [7:0]  data;
      logic        c;
      logic        z;
      logic [15:0] ret;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [2:0]  rd_slct_a, rd_slct_b, alu_op;
   logic [7:0]  data_out_a, data_out_b, alu_a, alu_b, alu_c, data_in;
   logic        alu_carry, alu_zero, wrtnbl, flag_carry, flag_zero, done;
   logic [6:0]  wrt_slct;
   logic [15:0] retired;
   logic [8:0]  wide;

   logic [7:0] rf_a [8] = '{8'h00, 8'h06, 8'h05, 8'hC8, 8'h00, 8'h0F, 8'h00, 8'h00};
   logic [7:0] rf_b [8] = '{8'h00, 8'h64, 8'h15, 8'h00, 8'h05, 8'h33, 8'h00, 8'h00};

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   exp_t exp_q [$];
   int   acc_q [$];
   exp_t mon_e;
   int   mon_a;
   logic seen_wr = 1'b0;
   logic [6:0] wr_slct_s;
   logic [7:0] wr_data_s;
   int   wr_cyc;

   always #5 clk = ~clk;

   alu_ctrl_if bus ();

   alu_ctrl #(.CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_if      (bus),
      .rd_slct_a  (rd_slct_a),
      .rd_slct_b  (rd_slct_b),
      .data_out_a (data_out_a),
      .data_out_b (data_out_b),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_c      (alu_c),
      .alu_carry  (alu_carry),
      .alu_zero   (alu_zero),
      .wrtnbl     (wrtnbl),
      .wrt_slct   (wrt_slct),
      .data_in    (data_in),
      .flag_carry (flag_carry),
      .flag_zero  (flag_zero),
      .done       (done),
      .retired    (retired)
   );

   assign data_out_a = rf_a[rd_slct_a];
   assign data_out_b = rf_b[rd_slct_b];

   always @(posedge clk) begin
      if (wrtnbl) begin
         if (wrt_slct[3]) rf_b[wrt_slct[2:0]] <= data_in;
         else             rf_a[wrt_slct[2:0]] <= data_in;
      end
   end

   // Reference ALU; carry on sub is the borrow out.
   always_comb begin
      wide      = '0;
      alu_c     = '0;
      alu_carry = 1'b0;
      case (alu_op)
         3'b000: begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_c = wide[7:0]; alu_carry = wide[8]; end
         3'b001: begin wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_c = wide[7:0]; alu_carry = wide[8]; end
         3'b010: alu_c = alu_a & alu_b;
         3'b011: alu_c = alu_a | alu_b;
         3'b100: alu_c = ~(alu_a | alu_b);
         3'b101: alu_c = alu_a ^ alu_b;
         3'b110: alu_c = ~(alu_a ^ alu_b);
         default: alu_c = ~(alu_a & alu_b);
      endcase
      alu_zero = (alu_c == 8'h00);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] enc(input logic [2:0] op, input logic bank,
                                       input logic [2:0] dst, input logic [2:0] sa,
                                       input logic [2:0] sb);
      return {op, bank, dst, sa, sb, 3'b101};
   endfunction

   function automatic exp_t mk(input logic wr, input logic [6:0] slct, input logic [7:0] data,
                               input logic c, input logic z, input logic [15:0] ret);
      exp_t e;
      e.wr = wr; e.slct = slct; e.data = data; e.c = c; e.z = z; e.ret = ret;
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [15:0] w, input bit push, input exp_t e, input bit hold);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_instr = w;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
         bus.in_valid = 1'b0;
         return;
      end
      if (push) exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (!hold) bus.in_valid = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"},   bus.in_ready, 1);
      chk({tag, "_wrtnbl"},     wrtnbl, 0);
      chk({tag, "_done"},       done, 0);
      chk({tag, "_retired"},    retired, 0);
      chk({tag, "_flag_carry"}, flag_carry, 0);
      chk({tag, "_flag_zero"},  flag_zero, 0);
      chk({tag, "_rd_slct"},    {rd_slct_a, rd_slct_b}, 0);
      chk({tag, "_alu_ops"},    {alu_a, alu_b, alu_op}, 0);
      chk({tag, "_wr_bus"},     {wrt_slct, data_in}, 0);
   endtask

   always @(posedge clk) begin
      if (rst_n && bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         acc_q.delete();
         seen_wr = 1'b0;
      end else begin
         if (wrtnbl) begin
            seen_wr   = 1'b1;
            wr_slct_s = wrt_slct;
            wr_data_s = data_in;
            wr_cyc    = cyc;
            chk("ready_low_in_write", bus.in_ready, 0);
         end
         if (done) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: done=1 with %0d responses pending, required none",
                        exp_q.size());
            end else begin
               mon_e = exp_q.pop_front();
               mon_a = acc_q.pop_front();
               chk("done_latency", cyc - mon_a, 4);
               chk("write_seen", seen_wr, mon_e.wr);
               if (mon_e.wr && seen_wr) begin
                  chk("write_latency", wr_cyc - mon_a, 3);
                  chk("wrt_slct", wr_slct_s, mon_e.slct);
                  chk("data_in", wr_data_s, mon_e.data);
               end
               chk("flag_carry", flag_carry, mon_e.c);
               chk("flag_zero", flag_zero, mon_e.z);
               chk("retired", retired, mon_e.ret);
            end
            seen_wr = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      bus.in_valid = 1'b0;
      bus.in_instr = '0;
      #2 rst_n = 1'b0;
      #10 chk_reset("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      issue(enc(3'b010, 1'b1, 3'd3, 3'd1, 3'd2), 1, mk(1, 7'b0001011, 8'h04, 0, 0, 16'd1), 0);
      issue(enc(3'b000, 1'b0, 3'd4, 3'd3, 3'd1), 1, mk(1, 7'b0000100, 8'h2C, 1, 0, 16'd2), 0);
      issue(enc(3'b001, 1'b0, 3'd6, 3'd2, 3'd4), 1, mk(1, 7'b0000110, 8'h00, 0, 1, 16'd3), 0);
      issue(enc(3'b011, 1'b1, 3'd7, 3'd5, 3'd0), 1, mk(1, 7'b0001111, 8'h0F, 0, 0, 16'd4), 0);
      // Destination A0: no write, flags and count still update.
      issue(enc(3'b001, 1'b0, 3'd0, 3'd2, 3'd4), 1, mk(0, 7'b0000000, 8'h00, 0, 1, 16'd5), 0);

      // in_valid held high across three words; second and third read the previous result.
      issue(enc(3'b000, 1'b0, 3'd7, 3'd4, 3'd3), 1, mk(1, 7'b0000111, 8'h30, 0, 0, 16'd6), 1);
      issue(enc(3'b100, 1'b1, 3'd1, 3'd7, 3'd7), 1, mk(1, 7'b0001001, 8'hC0, 0, 0, 16'd7), 1);
      issue(enc(3'b111, 1'b0, 3'd2, 3'd1, 3'd1), 1, mk(1, 7'b0000010, 8'hFF, 0, 0, 16'd8), 0);

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);

      // Abort an instruction in EXEC; B5 must keep its old value.
      issue(enc(3'b101, 1'b1, 3'd5, 3'd1, 3'd2), 0, mk(0, 7'd0, 8'd0, 0, 0, 16'd0), 0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_reset("mid");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      issue(enc(3'b110, 1'b0, 3'd3, 3'd5, 3'd5), 1, mk(1, 7'b0000011, 8'hC3, 0, 0, 16'd1), 0);
      issue(enc(3'b001, 1'b1, 3'd4, 3'd1, 3'd1), 1, mk(1, 7'b0001100, 8'h46, 1, 0, 16'd2), 0);

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d responses pending, required 0", exp_q.size());
      end
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
